// File: rtl/audio_pkg.sv
// Shared types and constants for the stereo BRAM delay line.
package audio_pkg;
  localparam int SAMPLE_W = 16;
  localparam int RAM_AW   = 11;
  localparam int FRM_W    = RAM_AW - 1;

  localparam logic CH_L = 1'b0;
  localparam logic CH_R = 1'b1;

  typedef enum logic [1:0] {
    IDLE,
    RD_L,
    RD_R
  } rd_state_e;
endpackage

// File: rtl/audio_dly_ctrl_if.sv
// Simple dual-port BRAM bus: port A writes, port B reads with 1-cycle latency.
interface audio_dly_ctrl_if #(
  parameter int AW = audio_pkg::RAM_AW,
  parameter int DW = audio_pkg::SAMPLE_W
);
  logic          ram_cea;
  logic [AW-1:0] ram_ada;
  logic [DW-1:0] ram_din;
  logic          ram_ceb;
  logic          ram_oce;
  logic [AW-1:0] ram_adb;
  logic          ram_reset;
  logic [DW-1:0] ram_dout;

  modport master (
    output ram_cea, ram_ada, ram_din, ram_ceb, ram_oce, ram_adb, ram_reset,
    input  ram_dout
  );

  modport slave (
    input  ram_cea, ram_ada, ram_din, ram_ceb, ram_oce, ram_adb, ram_reset,
    output ram_dout
  );
endinterface

// File: rtl/audio_dly_rdseq.sv
// Read sequencer: after each committed frame, fetches the delayed L/R pair
// from port B and aligns strobe, channel and mute with the BRAM latency.
module audio_dly_rdseq
  import audio_pkg::*;
#(
  parameter int AW = RAM_AW,
  parameter int DW = SAMPLE_W
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          clr,
  input  logic          r_commit,
  input  logic [AW-2:0] wr_frm,
  input  logic [AW-2:0] dly_q,
  input  logic [AW-1:0] fill,
  input  logic [DW-1:0] ram_dout,
  output logic          ram_ceb,
  output logic [AW-1:0] ram_adb,
  output logic          overrun,
  output logic          out_valid,
  output logic          out_ch,
  output logic [DW-1:0] out_data
);
  rd_state_e     state, nxt;
  logic          start_q;
  logic          busy;
  logic [AW-2:0] rd_frm;
  logic          mute_q;
  logic          mute_d;

  // A frame arriving while a fetch is pending or running is stored but not read.
  assign busy    = start_q | (state != IDLE);
  assign overrun = r_commit & busy;

  // NOTE: state is written with <= so every flop samples pre-edge values;
  // blocking here would make the result depend on process ordering.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      start_q <= 1'b0;
    end else if (clr) begin
      state   <= IDLE;
      start_q <= 1'b0;
    end else begin
      state   <= nxt;
      start_q <= r_commit & ~busy;
    end
  end

  // NOTE: default first, so no path through the case leaves nxt unassigned
  // (which would infer a latch).
  always_comb begin
    nxt = state;
    case (state)
      IDLE:    if (start_q) nxt = RD_L;
      RD_L:    nxt = RD_R;
      RD_R:    nxt = IDLE;
      default: nxt = IDLE;
    endcase
  end

  always_comb begin
    ram_ceb = (state == RD_L) || (state == RD_R);
    ram_adb = '0;
    if (ram_ceb) ram_adb = {rd_frm, (state == RD_R) ? CH_R : CH_L};
  end

  // wr_frm has already advanced past the completed frame, hence the extra -1;
  // fill is post-increment, so delay >= fill means the slot was never written.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_frm <= '0;
      mute_q <= 1'b0;
    end else if (state == IDLE && start_q) begin
      rd_frm <= wr_frm - dly_q - 1'b1;
      mute_q <= ({1'b0, dly_q} >= fill);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_ch    <= 1'b0;
      mute_d    <= 1'b0;
    end else begin
      out_valid <= ram_ceb & ~clr;
      out_ch    <= ram_adb[0];
      mute_d    <= mute_q;
    end
  end

  assign out_data = (out_valid && !mute_d) ? ram_dout : '0;
endmodule

// File: rtl/audio_dly_ctrl.sv
// Stereo circular delay line controller: writes interleaved L/R samples on
// BRAM port A and replays the frame written `delay` frames earlier.
module audio_dly_ctrl
  import audio_pkg::*;
#(
  parameter int AW = RAM_AW,
  parameter int DW = SAMPLE_W
) (
  input  logic            sys_clk,
  input  logic            sys_rst_n,
  input  logic            clr,
  input  logic [AW-2:0]   delay,
  input  logic            in_valid,
  input  logic            in_ch,
  input  logic [DW-1:0]   in_data,
  output logic            out_valid,
  output logic            out_ch,
  output logic [DW-1:0]   out_data,
  output logic            ovf,
  audio_dly_ctrl_if.master ram
);
  localparam int FW = AW - 1;
  localparam logic [FW:0] FILL_MAX = {1'b1, {FW{1'b0}}};

  logic [FW-1:0] wr_frm;
  logic [FW-1:0] dly_q;
  logic [FW:0]   fill;
  logic          wr_en;
  logic          r_commit;
  logic          overrun;

  // Reset gating keeps the write port quiet while the controller is held.
  assign wr_en    = in_valid & ~clr & sys_rst_n;
  assign r_commit = wr_en & (in_ch == CH_R);

  assign ram.ram_cea   = wr_en;
  assign ram.ram_ada   = sys_rst_n ? {wr_frm, in_ch} : '0;
  assign ram.ram_din   = sys_rst_n ? in_data : '0;
  assign ram.ram_oce   = 1'b1;
  assign ram.ram_reset = 1'b0;

  // The frame pointer and delay latch only move on R, so a frame is atomic.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      wr_frm <= '0;
      fill   <= '0;
      dly_q  <= '0;
      ovf    <= 1'b0;
    end else if (clr) begin
      wr_frm <= '0;
      fill   <= '0;
      ovf    <= 1'b0;
    end else begin
      if (r_commit) begin
        wr_frm <= wr_frm + 1'b1;
        dly_q  <= delay;
        if (fill != FILL_MAX) fill <= fill + 1'b1;
      end
      if (overrun) ovf <= 1'b1;
    end
  end

  audio_dly_rdseq #(.AW(AW), .DW(DW)) u_rdseq (
    .clk      (sys_clk),
    .rst_n    (sys_rst_n),
    .clr      (clr),
    .r_commit (r_commit),
    .wr_frm   (wr_frm),
    .dly_q    (dly_q),
    .fill     (fill),
    .ram_dout (ram.ram_dout),
    .ram_ceb  (ram.ram_ceb),
    .ram_adb  (ram.ram_adb),
    .overrun  (overrun),
    .out_valid(out_valid),
    .out_ch   (out_ch),
    .out_data (out_data)
  );
endmodule

// File: tb/tb_audio_dly_ctrl.sv
// Directed bench for audio_dly_ctrl with a behavioural BRAM and a frame-history scoreboard.
`timescale 1ns/1ps
module tb_audio_dly_ctrl;
  import audio_pkg::*;

  logic             sys_clk   = 1'b0;
  logic             sys_rst_n = 1'b1;
  logic             clr       = 1'b0;
  logic [FRM_W-1:0] delay     = '0;
  logic             in_valid  = 1'b0;
  logic             in_ch     = 1'b0;
  logic [15:0]      in_data   = '0;
  logic             out_valid;
  logic             out_ch;
  logic [15:0]      out_data;
  logic             ovf;

  audio_dly_ctrl_if #(.AW(RAM_AW), .DW(SAMPLE_W)) ram_bus ();

  audio_dly_ctrl dut (
    .sys_clk  (sys_clk),
    .sys_rst_n(sys_rst_n),
    .clr      (clr),
    .delay    (delay),
    .in_valid (in_valid),
    .in_ch    (in_ch),
    .in_data  (in_data),
    .out_valid(out_valid),
    .out_ch   (out_ch),
    .out_data (out_data),
    .ovf      (ovf),
    .ram      (ram_bus)
  );

  always #5 sys_clk = ~sys_clk;

  // Behavioural simple dual-port BRAM, 1-cycle read latency.
  logic [15:0] mem [0:2047];
  always @(posedge sys_clk) begin
    if (ram_bus.ram_cea) mem[ram_bus.ram_ada] <= ram_bus.ram_din;
    if (ram_bus.ram_ceb) ram_bus.ram_dout <= mem[ram_bus.ram_adb];
  end

  typedef struct {
    logic        ch;
    logic [15:0] data;
  } exp_t;

  exp_t        exp_q[$];
  exp_t        e_mon;
  int          total = 0;
  int          bad   = 0;
  logic [15:0] h_l [0:1023];
  logic [15:0] h_r [0:1023];
  int          m_wr   = 0;
  int          m_fill = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    total++;
    assert (obs === expv) else begin
      bad++;
      $error("FAIL %s: got %0h want %0h", tag, obs, expv);
    end
  endtask

  always @(negedge sys_clk) begin
    if (out_valid === 1'b1) begin
      if (exp_q.size() == 0) begin
        check("spurious_out", 32'(out_valid), 32'd0);
      end else begin
        e_mon = exp_q.pop_front();
        check("out_ch", 32'(out_ch), 32'(e_mon.ch));
        check("out_data", 32'(out_data), 32'(e_mon.data));
      end
    end
  end

  task automatic step(input logic v, input logic ch, input logic [15:0] d);
    @(posedge sys_clk);
    #1;
    in_valid = v;
    in_ch    = ch;
    in_data  = d;
  endtask

  task automatic idle(input int n);
    repeat (n) step(1'b0, CH_L, 16'h0);
  endtask

  // Expected output of one completed frame, from the bench's own frame history.
  task automatic model_frame(input logic [15:0] l, input logic [15:0] r, input int dly,
                             input bit expect_rd);
    int   rd;
    bit   mute;
    exp_t e;
    h_l[m_wr] = l;
    h_r[m_wr] = r;
    m_wr = (m_wr + 1) % 1024;
    if (m_fill < 1024) m_fill++;
    rd   = (m_wr + 2047 - dly) % 1024;
    mute = (dly >= m_fill);
    if (expect_rd) begin
      e.ch = CH_L; e.data = mute ? 16'h0 : h_l[rd]; exp_q.push_back(e);
      e.ch = CH_R; e.data = mute ? 16'h0 : h_r[rd]; exp_q.push_back(e);
    end
  endtask

  task automatic send_frame(input logic [15:0] l, input logic [15:0] r, input int dl,
                            input int dr, input int gap, input bit expect_rd);
    @(posedge sys_clk);
    #1;
    in_valid = 1'b1; in_ch = CH_L; in_data = l; delay = FRM_W'(dl);
    @(posedge sys_clk);
    #1;
    in_ch = CH_R; in_data = r; delay = FRM_W'(dr);
    model_frame(l, r, dr, expect_rd);
    idle(gap + 1);
  endtask

  task automatic pulse_clr();
    @(posedge sys_clk);
    #1;
    in_valid = 1'b0; clr = 1'b1;
    @(posedge sys_clk);
    #1;
    clr = 1'b0;
    m_wr = 0;
    m_fill = 0;
  endtask

  task automatic drain(input string tag);
    idle(8);
    check(tag, 32'(exp_q.size()), 32'd0);
  endtask

  task automatic check_quiet(input string tag);
    check({tag, "_out_valid"}, 32'(out_valid), 32'd0);
    check({tag, "_out_ch"}, 32'(out_ch), 32'd0);
    check({tag, "_out_data"}, 32'(out_data), 32'd0);
    check({tag, "_ovf"}, 32'(ovf), 32'd0);
    check({tag, "_cea"}, 32'(ram_bus.ram_cea), 32'd0);
    check({tag, "_ceb"}, 32'(ram_bus.ram_ceb), 32'd0);
    check({tag, "_ada"}, 32'(ram_bus.ram_ada), 32'd0);
    check({tag, "_adb"}, 32'(ram_bus.ram_adb), 32'd0);
    check({tag, "_din"}, 32'(ram_bus.ram_din), 32'd0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    // Reset state
    #2 sys_rst_n = 1'b0;
    #20;
    check_quiet("reset");
    check("reset_oce", 32'(ram_bus.ram_oce), 32'd1);
    check("reset_ramrst", 32'(ram_bus.ram_reset), 32'd0);
    @(negedge sys_clk);
    sys_rst_n = 1'b1;

    // delay=0 passthrough with explicit latency checks
    step(1'b1, CH_L, 16'h1111);
    @(negedge sys_clk);
    check("t1_cea_l", 32'(ram_bus.ram_cea), 32'd1);
    check("t1_ada_l", 32'(ram_bus.ram_ada), 32'd0);
    step(1'b1, CH_R, 16'h2222);
    model_frame(16'h1111, 16'h2222, 0, 1'b1);
    @(negedge sys_clk);
    check("t1_ada_r", 32'(ram_bus.ram_ada), 32'd1);
    step(1'b0, CH_L, 16'h0);
    @(negedge sys_clk);
    check("t1_lat_c1", 32'(out_valid), 32'd0);
    @(negedge sys_clk);
    check("t1_lat_c2", 32'(out_valid), 32'd0);
    check("t1_ceb", 32'(ram_bus.ram_ceb), 32'd1);
    check("t1_adb", 32'(ram_bus.ram_adb), 32'd0);
    @(negedge sys_clk);
    check("t1_lat_c3", 32'(out_valid), 32'd1);
    @(negedge sys_clk);
    check("t1_lat_c4", 32'(out_valid), 32'd1);
    drain("t1_drain");

    // delay=3: three muted frames, then real history
    pulse_clr();
    for (int k = 0; k < 8; k++) send_frame(16'(k), 16'(16'h100 + k), 3, 3, 3, 1'b1);
    drain("t2_drain");

    // delay=1023 with pointer wrap
    pulse_clr();
    for (int k = 0; k < 1100; k++) send_frame(16'(k), 16'(16'h8000 + k), 1023, 1023, 2, 1'b1);
    drain("t3_drain");

    // delay change between L and R of one frame
    pulse_clr();
    for (int k = 0; k < 8; k++) send_frame(16'(16'h4000 + k), 16'(16'h5000 + k), 2, 2, 3, 1'b1);
    send_frame(16'h4008, 16'h5008, 2, 5, 3, 1'b1);
    drain("t4_drain");

    // Overrun: R writes two cycles apart
    pulse_clr();
    check("t5_ovf_pre", 32'(ovf), 32'd0);
    send_frame(16'hAAAA, 16'hA0A0, 0, 0, -1, 1'b1);
    send_frame(16'hBBBB, 16'hB0B0, 0, 0, 3, 1'b0);
    drain("t5_drain");
    check("t5_ovf", 32'(ovf), 32'd1);
    check("t5_mem0", 32'(mem[0]), 32'hAAAA);
    check("t5_mem1", 32'(mem[1]), 32'hA0A0);
    check("t5_mem2", 32'(mem[2]), 32'hBBBB);
    check("t5_mem3", 32'(mem[3]), 32'hB0B0);
    pulse_clr();
    @(negedge sys_clk);
    check("t5_ovf_clr", 32'(ovf), 32'd0);
    send_frame(16'h1234, 16'h5678, 1, 1, 3, 1'b1);
    send_frame(16'h9ABC, 16'hDEF0, 1, 1, 3, 1'b1);
    drain("t5_clr_drain");

    // Reset during a read sequence
    step(1'b1, CH_L, 16'h7777);
    step(1'b1, CH_R, 16'h8888);
    step(1'b0, CH_L, 16'h0);
    @(posedge sys_clk);
    @(posedge sys_clk);
    #1 sys_rst_n = 1'b0;
    #1;
    check_quiet("midrst");
    idle(2);
    @(negedge sys_clk);
    sys_rst_n = 1'b1;
    m_wr = 0;
    m_fill = 0;
    idle(4);
    send_frame(16'h0F0F, 16'hF0F0, 0, 0, 3, 1'b1);
    drain("t6_drain");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
